// File: rtl/inst_fetch_if.sv
// Handshake and memory-bus bundle between the fetch unit (master), the control FSM,
// the branch/jump path and instruction memory (slave side).
interface inst_fetch_if;
  logic        fetch_req;
  logic        ack;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    input  fetch_req, pc_load, pc_load_addr, imem_rvalid, imem_rdata,
    output ack, instruction, instr_pc, imem_rd_en, imem_addr
  );

  modport slave (
    output fetch_req, pc_load, pc_load_addr, imem_rvalid, imem_rdata,
    input  ack, instruction, instr_pc, imem_rd_en, imem_addr
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: fetch PC, in-order memory requests, 2-entry prefetch queue,
// and redirect handling that discards stale queued and in-flight words.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0] fetch_pc,  fetch_pc_n;
  logic [31:0] q_instr   [DEPTH];
  logic [31:0] q_instr_n [DEPTH];
  logic [31:0] q_pc      [DEPTH];
  logic [31:0] q_pc_n    [DEPTH];
  logic [31:0] out_pc    [DEPTH];
  logic [31:0] out_pc_n  [DEPTH];
  cnt_t        count, count_n;
  cnt_t        outstanding, outstanding_n;
  cnt_t        drop_cnt, drop_n;

  logic ack, pop, push, resp, issue;
  cnt_t occ_after_pop, wr_idx, iss_idx;

  assign resp          = bus.imem_rvalid;
  assign ack           = (count != '0) && !bus.pc_load;
  assign pop           = bus.fetch_req && ack;
  assign push          = resp && (drop_cnt == '0) && !bus.pc_load;
  assign occ_after_pop = count + outstanding - cnt_t'(pop);
  assign issue         = !rst && !bus.pc_load && (occ_after_pop < DEPTH_C);
  assign wr_idx        = count - cnt_t'(pop);
  assign iss_idx       = outstanding - cnt_t'(resp);

  // Head entry is zeroed whenever the queue is empty, so outputs come straight from flops.
  assign bus.ack         = ack;
  assign bus.instruction = q_instr[0];
  assign bus.instr_pc    = q_pc[0];
  assign bus.imem_rd_en  = issue;
  assign bus.imem_addr   = fetch_pc;

  always_comb begin
    // NOTE: every next-state variable is defaulted first so no path leaves it unassigned (no latch).
    fetch_pc_n    = fetch_pc;
    q_instr_n     = q_instr;
    q_pc_n        = q_pc;
    out_pc_n      = out_pc;
    count_n       = count;
    outstanding_n = outstanding + cnt_t'(issue) - cnt_t'(resp);
    drop_n        = drop_cnt;

    // Outstanding-request pc tracker: shift out on response, append on issue.
    if (resp) begin
      for (int i = 0; i < DEPTH - 1; i++) out_pc_n[i] = out_pc[i+1];
      out_pc_n[DEPTH-1] = '0;
    end
    if (issue) begin
      for (int i = 0; i < DEPTH; i++)
        if (cnt_t'(i) == iss_idx) out_pc_n[i] = fetch_pc;
    end

    if (bus.pc_load) begin
      fetch_pc_n = {bus.pc_load_addr[31:2], 2'b00};
      drop_n     = outstanding - cnt_t'(resp);
      count_n    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_n[i] = '0;
        q_pc_n[i]    = '0;
      end
    end else begin
      if (issue) fetch_pc_n = fetch_pc + 32'd4;
      if (resp && (drop_cnt != '0)) drop_n = drop_cnt - cnt_t'(1);
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          q_instr_n[i] = q_instr[i+1];
          q_pc_n[i]    = q_pc[i+1];
        end
        q_instr_n[DEPTH-1] = '0;
        q_pc_n[DEPTH-1]    = '0;
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_t'(i) == wr_idx) begin
            q_instr_n[i] = bus.imem_rdata;
            q_pc_n[i]    = out_pc[0];
          end
        end
      end
      count_n = count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      // NOTE: queue storage is reset because its head drives instruction/instr_pc directly.
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        out_pc[i]  <= '0;
      end
    end else begin
      fetch_pc    <= fetch_pc_n;
      count       <= count_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_n;
      q_instr     <= q_instr_n;
      q_pc        <= q_pc_n;
      out_pc      <= out_pc_n;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with an in-order fixed-latency instruction memory model.
module tb_inst_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat = 1;
  int   cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pend[$];

  inst_fetch_if bus();

  inst_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]} ^ {a[31:16], 16'h0000};
  endfunction

  // Memory: record the request of the cycle just ended, then present the response due now.
  always @(posedge clk) begin
    if (rst) pend.delete();
    else if (bus.imem_rd_en) pend.push_back('{addr: bus.imem_addr, due: cyc + lat});
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst) assert (!(dut.push && !dut.pop && dut.count == 2'd2))
      else $error("FAIL q_overflow: push into full queue without pop");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_issue(input string tag, input logic en, input logic [31:0] addr);
    check({tag, ".rd_en"}, {31'b0, bus.imem_rd_en}, {31'b0, en});
    check({tag, ".addr"}, bus.imem_addr, addr);
  endtask

  task automatic exp_fetch(input string tag, input logic a, input logic [31:0] pc);
    check({tag, ".ack"}, {31'b0, bus.ack}, {31'b0, a});
    check({tag, ".pc"}, bus.instr_pc, a ? pc : 32'h0);
    check({tag, ".instr"}, bus.instruction, a ? mem_word(pc) : 32'h0);
  endtask

  task automatic exp_ack(input string tag, input logic a);
    check({tag, ".ack"}, {31'b0, bus.ack}, {31'b0, a});
  endtask

  // Leaves the caller at the negedge that starts cycle 0 with rst already low.
  task automatic do_reset(input int l);
    @(negedge clk);
    rst = 1'b1;
    bus.fetch_req = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_load_addr = 32'h0;
    lat = l;
    @(negedge clk);
    #1;
    exp_issue("rst", 1'b0, RST_PC);
    exp_fetch("rst", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.fetch_req = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_load_addr = 32'h0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;

    // L=1, fetch_req held: one instruction per cycle from cycle 2.
    do_reset(1);
    bus.fetch_req = 1'b1;
    #1; exp_issue("t1c0", 1'b1, 32'h0); exp_fetch("t1c0", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t1c1", 1'b1, 32'h4); exp_fetch("t1c1", 1'b0, 32'h0);
    for (int k = 2; k < 8; k++) begin
      @(negedge clk); #1;
      exp_issue($sformatf("t1c%0d", k), 1'b1, 32'(4 * k));
      exp_fetch($sformatf("t1c%0d", k), 1'b1, 32'(4 * (k - 2)));
    end

    // L=1, fetch_req low: queue fills, issue stops, one pop frees a slot.
    do_reset(1);
    #1; exp_issue("t2c0", 1'b1, 32'h0);
    @(negedge clk); #1; exp_issue("t2c1", 1'b1, 32'h4); exp_fetch("t2c1", 1'b0, 32'h0);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk); #1;
      exp_issue($sformatf("t2c%0d", k), 1'b0, 32'h8);
      exp_fetch($sformatf("t2c%0d", k), 1'b1, 32'h0);
    end
    @(negedge clk); bus.fetch_req = 1'b1;
    #1; exp_issue("t2pop", 1'b1, 32'h8); exp_fetch("t2pop", 1'b1, 32'h0);
    @(negedge clk); bus.fetch_req = 1'b0;
    #1; exp_issue("t2after", 1'b0, 32'hC); exp_fetch("t2after", 1'b1, 32'h4);

    // L=3, two in flight, redirect to unaligned 0x103: both late words dropped.
    do_reset(3);
    bus.fetch_req = 1'b1;
    #1; exp_issue("t3c0", 1'b1, 32'h0);
    @(negedge clk); #1; exp_issue("t3c1", 1'b1, 32'h4);
    @(negedge clk); bus.pc_load = 1'b1; bus.pc_load_addr = 32'h0000_0103;
    #1; exp_issue("t3c2", 1'b0, 32'h8); exp_ack("t3c2", 1'b0);
    @(negedge clk); bus.pc_load = 1'b0;
    #1; exp_issue("t3c3", 1'b0, 32'h100); exp_fetch("t3c3", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t3c4", 1'b1, 32'h100); exp_fetch("t3c4", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t3c5", 1'b1, 32'h104); exp_fetch("t3c5", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t3c6", 1'b0, 32'h108); exp_fetch("t3c6", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t3c7", 1'b0, 32'h108); exp_fetch("t3c7", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t3c8", 1'b1, 32'h108); exp_fetch("t3c8", 1'b1, 32'h100);
    @(negedge clk); #1; exp_fetch("t3c9", 1'b1, 32'h104);

    // L=1, redirect coinciding with the pc 4 response while pc 0 is queued.
    do_reset(1);
    #1; exp_issue("t4c0", 1'b1, 32'h0);
    @(negedge clk); #1; exp_issue("t4c1", 1'b1, 32'h4);
    @(negedge clk); bus.pc_load = 1'b1; bus.pc_load_addr = 32'h200; bus.fetch_req = 1'b1;
    #1; exp_issue("t4c2", 1'b0, 32'h8); exp_ack("t4c2", 1'b0);
    check("t4c2.head", bus.instruction, mem_word(32'h0));
    @(negedge clk); bus.pc_load = 1'b0;
    #1; exp_issue("t4c3", 1'b1, 32'h200); exp_fetch("t4c3", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t4c4", 1'b1, 32'h204); exp_fetch("t4c4", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t4c5", 1'b1, 32'h208); exp_fetch("t4c5", 1'b1, 32'h200);

    // L=3, back-to-back redirects: last target wins, drop count recomputed.
    do_reset(3);
    bus.fetch_req = 1'b1;
    #1; exp_issue("t5c0", 1'b1, 32'h0);
    @(negedge clk); #1; exp_issue("t5c1", 1'b1, 32'h4);
    @(negedge clk); bus.pc_load = 1'b1; bus.pc_load_addr = 32'h300;
    #1; exp_issue("t5c2", 1'b0, 32'h8); exp_ack("t5c2", 1'b0);
    @(negedge clk); bus.pc_load_addr = 32'h400;
    #1; exp_issue("t5c3", 1'b0, 32'h300); exp_ack("t5c3", 1'b0);
    @(negedge clk); bus.pc_load = 1'b0;
    #1; exp_issue("t5c4", 1'b1, 32'h400); exp_fetch("t5c4", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t5c5", 1'b1, 32'h404); exp_fetch("t5c5", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t5c6", 1'b0, 32'h408); exp_fetch("t5c6", 1'b0, 32'h0);
    @(negedge clk); #1; exp_fetch("t5c7", 1'b0, 32'h0);
    @(negedge clk); #1; exp_issue("t5c8", 1'b1, 32'h408); exp_fetch("t5c8", 1'b1, 32'h400);

    // L=1, sequential fetch across the top of the address space.
    do_reset(1);
    bus.fetch_req = 1'b1; bus.pc_load = 1'b1; bus.pc_load_addr = 32'hFFFF_FFFC;
    #1; exp_issue("t6c0", 1'b0, RST_PC);
    @(negedge clk); bus.pc_load = 1'b0;
    #1; exp_issue("t6c1", 1'b1, 32'hFFFF_FFFC);
    @(negedge clk); #1; exp_issue("t6c2", 1'b1, 32'h0);
    @(negedge clk); #1; exp_issue("t6c3", 1'b1, 32'h4); exp_fetch("t6c3", 1'b1, 32'hFFFF_FFFC);
    @(negedge clk); #1; exp_fetch("t6c4", 1'b1, 32'h0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
